// File: rtl/uarch_pkg.sv
// Shared micro-architecture constants and types for the front end.
// Fetch-queue defaults are taken from here by fetch_queue and its helpers.
package uarch_pkg;

    localparam int CPU_ADDR_BITS     = 32;
    localparam int CPU_INST_BITS     = 32;
    localparam int CPU_FETCH_WIDTH   = 2;
    localparam int CPU_PIPE_WIDTH    = 2;
    localparam int FETCH_QUEUE_DEPTH = 8;

    typedef struct packed {
        logic [CPU_ADDR_BITS-1:0] pc;
        logic [CPU_INST_BITS-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_lane_compact.sv
// Packs the contiguous valid run of a fetch packet down to lane 0 and
// derives each packed lane's PC from the packet base PC.
module fetch_lane_compact
    import uarch_pkg::*;
#(
    parameter int FETCH_WIDTH = CPU_FETCH_WIDTH,
    parameter int ADDR_BITS   = CPU_ADDR_BITS,
    parameter int INST_BITS   = CPU_INST_BITS
) (
    input  logic [FETCH_WIDTH-1:0]           i_mask,
    input  logic [ADDR_BITS-1:0]             i_base_pc,
    input  logic [FETCH_WIDTH*INST_BITS-1:0] i_lanes,
    output logic [$clog2(FETCH_WIDTH+1)-1:0] o_num,
    output logic [FETCH_WIDTH*INST_BITS-1:0] o_insts,
    output logic [FETCH_WIDTH*ADDR_BITS-1:0] o_pcs
);

    localparam int LN_W = $clog2(FETCH_WIDTH + 1);

    logic [LN_W-1:0] w_start;

    // Downward scan leaves the lowest set lane as the start index.
    always_comb begin
        w_start = '0;
        o_num   = '0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                w_start = LN_W'(i);
            end
        end
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            o_num = o_num + LN_W'(i_mask[i]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane
            logic [LN_W:0] w_src;
            assign w_src = (LN_W+1)'(w_start) + (LN_W+1)'(gi);
            assign o_insts[gi*INST_BITS +: INST_BITS] =
                (w_src < (LN_W+1)'(FETCH_WIDTH)) ? i_lanes[w_src*INST_BITS +: INST_BITS] : '0;
            assign o_pcs[gi*ADDR_BITS +: ADDR_BITS] = i_base_pc + (ADDR_BITS'(w_src) << 2);
        end
    endgenerate

endmodule

// File: rtl/fetch_queue.sv
// Instruction-granular fetch-to-decode queue: circular {pc, inst} storage,
// compacted multi-lane writes and prefix consumption by decode.
module fetch_queue
    import uarch_pkg::*;
#(
    parameter int FETCH_WIDTH = CPU_FETCH_WIDTH,
    parameter int PIPE_WIDTH  = CPU_PIPE_WIDTH,
    parameter int DEPTH       = FETCH_QUEUE_DEPTH,
    parameter int ADDR_BITS   = CPU_ADDR_BITS,
    parameter int INST_BITS   = CPU_INST_BITS
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              fetch_val,
    input  logic [ADDR_BITS-1:0]              fetch_pc,
    input  logic [FETCH_WIDTH*INST_BITS-1:0]  fetch_insts,
    input  logic [FETCH_WIDTH-1:0]            fetch_mask,
    output logic                              fetch_rdy,
    output logic [PIPE_WIDTH-1:0]             dec_val,
    output logic [PIPE_WIDTH*INST_BITS-1:0]   dec_insts,
    output logic [PIPE_WIDTH*ADDR_BITS-1:0]   dec_pcs,
    input  logic [$clog2(PIPE_WIDTH+1)-1:0]   dec_take,
    output logic [$clog2(DEPTH+1)-1:0]        count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int TAKE_W = $clog2(PIPE_WIDTH + 1);
    localparam int LN_W   = $clog2(FETCH_WIDTH + 1);

    logic [ADDR_BITS-1:0] r_pc_mem   [DEPTH];
    logic [INST_BITS-1:0] r_inst_mem [DEPTH];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;

    logic [LN_W-1:0]                  w_num;
    logic [LN_W-1:0]                  w_wr_num;
    logic [FETCH_WIDTH*INST_BITS-1:0] w_lane_insts;
    logic [FETCH_WIDTH*ADDR_BITS-1:0] w_lane_pcs;
    logic                             w_accept;
    logic [TAKE_W-1:0]                w_avail;
    logic [TAKE_W-1:0]                w_eff_take;

    fetch_lane_compact #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .ADDR_BITS   (ADDR_BITS),
        .INST_BITS   (INST_BITS)
    ) u_compact (
        .i_mask    (fetch_mask),
        .i_base_pc (fetch_pc),
        .i_lanes   (fetch_insts),
        .o_num     (w_num),
        .o_insts   (w_lane_insts),
        .o_pcs     (w_lane_pcs)
    );

    // Readiness looks only at registered occupancy, so a full queue stays
    // not-ready for the cycle in which decode drains it.
    assign fetch_rdy  = (r_count <= CNT_W'(DEPTH - FETCH_WIDTH));
    assign w_accept   = fetch_val & fetch_rdy & ~flush;
    assign w_wr_num   = w_accept ? w_num : '0;
    assign w_avail    = (r_count >= CNT_W'(PIPE_WIDTH)) ? TAKE_W'(PIPE_WIDTH) : TAKE_W'(r_count);
    assign w_eff_take = (dec_take > w_avail) ? w_avail : dec_take;
    assign count      = r_count;

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_WIDTH; gi++) begin : g_rd
            logic [PTR_W-1:0] w_idx;
            assign w_idx        = r_head + PTR_W'(gi);
            assign dec_val[gi]  = (r_count > CNT_W'(gi));
            assign dec_insts[gi*INST_BITS +: INST_BITS] = dec_val[gi] ? r_inst_mem[w_idx] : '0;
            assign dec_pcs[gi*ADDR_BITS +: ADDR_BITS]   = dec_val[gi] ? r_pc_mem[w_idx]   : '0;
        end
    endgenerate

    // Storage carries no reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (k < int'(w_num)) begin
                    r_pc_mem[r_tail + PTR_W'(k)]   <= w_lane_pcs[k*ADDR_BITS +: ADDR_BITS];
                    r_inst_mem[r_tail + PTR_W'(k)] <= w_lane_insts[k*INST_BITS +: INST_BITS];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_eff_take);
            r_tail  <= r_tail + PTR_W'(w_wr_num);
            r_count <= r_count + CNT_W'(w_wr_num) - CNT_W'(w_eff_take);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus pushes hand-computed entries into
// a scoreboard queue; a negedge monitor compares every presented lane.
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        fetch_val;
    logic [31:0] fetch_pc;
    logic [63:0] fetch_insts;
    logic [1:0]  fetch_mask;
    logic        fetch_rdy;
    logic [1:0]  dec_val;
    logic [63:0] dec_insts;
    logic [63:0] dec_pcs;
    logic [1:0]  dec_take;
    logic [3:0]  count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic overtake_seen = 1'b0;

    fetch_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .fetch_val   (fetch_val),
        .fetch_pc    (fetch_pc),
        .fetch_insts (fetch_insts),
        .fetch_mask  (fetch_mask),
        .fetch_rdy   (fetch_rdy),
        .dec_val     (dec_val),
        .dec_insts   (dec_insts),
        .dec_pcs     (dec_pcs),
        .dec_take    (dec_take),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic set_idle();
        fetch_val   = 1'b0;
        fetch_pc    = '0;
        fetch_insts = '0;
        fetch_mask  = '0;
        dec_take    = '0;
        flush       = 1'b0;
    endtask

    // One cycle of stimulus; en/p*/e* are the hand-computed entries the
    // queue is expected to accept at this edge.
    task automatic drive(input logic val, input logic [31:0] pc, input logic [31:0] i1,
                         input logic [31:0] i0, input logic [1:0] mask, input logic [1:0] take,
                         input logic fl, input int en, input logic [31:0] p0, input logic [31:0] e0,
                         input logic [31:0] p1, input logic [31:0] e1);
        int npop;
        fetch_val   = val;
        fetch_pc    = pc;
        fetch_insts = {i1, i0};
        fetch_mask  = mask;
        dec_take    = take;
        flush       = fl;
        $display("[TB] txn val=%0b pc=%08h mask=%02b take=%0d flush=%0b expect_accepted=%0d",
                 val, pc, mask, take, fl, en);
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            npop = (int'(take) > exp_q.size()) ? exp_q.size() : int'(take);
            repeat (npop) void'(exp_q.pop_front());
            if (en > 0) exp_q.push_back('{pc: p0, inst: e0});
            if (en > 1) exp_q.push_back('{pc: p1, inst: e1});
        end
        #1;
        set_idle();
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor: every presented lane must match the queue front.
    always @(negedge clk) begin
        if (rst_n) begin
            check("mon_count", 64'(count), 64'(exp_q.size()));
            check("mon_rdy", 64'(fetch_rdy), 64'(exp_q.size() <= 6));
            for (int j = 0; j < 2; j++) begin
                if (j < exp_q.size()) begin
                    check("mon_val", 64'(dec_val[j]), 64'd1);
                    check("mon_inst", 64'(dec_insts[j*32 +: 32]), 64'(exp_q[j].inst));
                    check("mon_pc", 64'(dec_pcs[j*32 +: 32]), 64'(exp_q[j].pc));
                end else begin
                    check("mon_val_off", 64'(dec_val[j]), 64'd0);
                    check("mon_lane_zero", {dec_insts[j*32 +: 32], dec_pcs[j*32 +: 32]}, 64'd0);
                end
            end
            if (int'(dec_take) > $countones(dec_val)) begin
                overtake_seen = 1'b1;
                $display("[TB] note: decode over-take requested take=%0d lanes=%0d",
                         dec_take, $countones(dec_val));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        settle();
        check("rst_rdy", 64'(fetch_rdy), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_val", 64'(dec_val), 64'd0);
        check("rst_data", dec_insts ^ dec_pcs, 64'd0);
        rst_n = 1'b1;

        // Single full packet
        drive(1, 32'h1000, 32'hB, 32'hA, 2'b11, 0, 0, 2, 32'h1000, 32'hA, 32'h1004, 32'hB);
        settle();
        check("wr1_count", 64'(count), 64'd2);
        check("wr1_val", 64'(dec_val), 64'd3);
        check("wr1_inst0", 64'(dec_insts[31:0]), 64'hA);
        check("wr1_pc1", 64'(dec_pcs[63:32]), 64'h1004);
        drive(0, 0, 0, 0, 2'b00, 2, 0, 0, 0, 0, 0, 0);

        // Unaligned and truncated packets
        drive(1, 32'h2000, 32'hD, 32'hC, 2'b10, 0, 0, 1, 32'h2004, 32'hD, 0, 0);
        settle();
        check("unal_val", 64'(dec_val), 64'd1);
        check("unal_pc", 64'(dec_pcs[31:0]), 64'h2004);
        drive(1, 32'h2000, 32'hF, 32'hE, 2'b01, 0, 0, 1, 32'h2000, 32'hE, 0, 0);
        drive(1, 32'h2010, 32'h0, 32'h12, 2'b01, 0, 0, 1, 32'h2010, 32'h12, 0, 0);
        settle();
        check("trunc_count", 64'(count), 64'd3);

        // Partial consume with simultaneous write
        drive(1, 32'h2020, 32'h14, 32'h13, 2'b11, 1, 0, 2, 32'h2020, 32'h13, 32'h2024, 32'h14);
        settle();
        check("pc_count", 64'(count), 64'd4);
        check("pc_head_pc", 64'(dec_pcs[31:0]), 64'h2000);
        check("pc_head_inst", 64'(dec_insts[31:0]), 64'hE);

        // Empty mask is a no-op
        drive(1, 32'h2030, 32'h16, 32'h15, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check("noop_count", 64'(count), 64'd4);

        // Flush beats a same-cycle write and consume
        drive(1, 32'h2040, 32'h18, 32'h17, 2'b11, 2, 1, 0, 0, 0, 0, 0);
        settle();
        check("flush_count", 64'(count), 64'd0);
        check("flush_val", 64'(dec_val), 64'd0);

        // Offset pointers to slot 2 so the fill wraps
        drive(1, 32'h4000, 32'h41, 32'h40, 2'b11, 0, 0, 2, 32'h4000, 32'h40, 32'h4004, 32'h41);
        drive(0, 0, 0, 0, 2'b00, 2, 0, 0, 0, 0, 0, 0);
        drive(1, 32'h5000, 32'h51, 32'h50, 2'b11, 0, 0, 2, 32'h5000, 32'h50, 32'h5004, 32'h51);
        drive(1, 32'h5008, 32'h53, 32'h52, 2'b11, 0, 0, 2, 32'h5008, 32'h52, 32'h500C, 32'h53);
        drive(1, 32'h5010, 32'h55, 32'h54, 2'b11, 0, 0, 2, 32'h5010, 32'h54, 32'h5014, 32'h55);
        drive(1, 32'h5018, 32'h57, 32'h56, 2'b11, 0, 0, 2, 32'h5018, 32'h56, 32'h501C, 32'h57);
        settle();
        check("full_count", 64'(count), 64'd8);
        check("full_rdy", 64'(fetch_rdy), 64'd0);
        // Fifth write blocked even though decode drains in the same cycle
        drive(1, 32'h5020, 32'h59, 32'h58, 2'b11, 2, 0, 0, 0, 0, 0, 0);
        settle();
        check("blk_count", 64'(count), 64'd6);
        check("blk_rdy", 64'(fetch_rdy), 64'd1);
        repeat (3) drive(0, 0, 0, 0, 2'b00, 2, 0, 0, 0, 0, 0, 0);
        settle();
        check("drain_count", 64'(count), 64'd0);

        // Asynchronous reset mid-drain
        drive(1, 32'h6000, 32'h61, 32'h60, 2'b11, 0, 0, 2, 32'h6000, 32'h60, 32'h6004, 32'h61);
        drive(1, 32'h6008, 32'h63, 32'h62, 2'b11, 0, 0, 2, 32'h6008, 32'h62, 32'h600C, 32'h63);
        drive(0, 0, 0, 0, 2'b00, 2, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_val", 64'(dec_val), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_rdy", 64'(fetch_rdy), 64'd1);
        check("arst_data", dec_insts | dec_pcs, 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1, 32'h7000, 32'h71, 32'h70, 2'b11, 0, 0, 2, 32'h7000, 32'h70, 32'h7004, 32'h71);
        settle();
        check("post_rst_slot0_pc", 64'(dut.r_pc_mem[0]), 64'h7000);
        check("post_rst_slot1_inst", 64'(dut.r_inst_mem[1]), 64'h71);
        check("no_overtake_yet", 64'(overtake_seen), 64'd0);

        // Over-take clamp
        drive(0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 2'b00, 2, 0, 0, 0, 0, 0, 0);
        settle();
        check("clamp_count", 64'(count), 64'd0);
        check("clamp_head", 64'(dut.r_head), 64'd2);
        check("clamp_flagged", 64'(overtake_seen), 64'd1);

        repeat (2) @(posedge clk);
        settle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-granular fetch-to-decode queue, the parametrised successor to the packet-granular instruction buffer. It accepts packets of up to FETCH_WIDTH instructions, each with a contiguous lane-valid mask so unaligned fetch targets and taken-branch truncation cost no slots. Each entry stores one instruction and its PC. Decode sees up to PIPE_WIDTH oldest instructions per cycle and may consume any prefix of them.

## Interface
Parameters:
- FETCH_WIDTH, 2: instruction lanes per fetch packet.
- PIPE_WIDTH, 2: decode lanes presented per cycle.
- DEPTH, 8: instruction slots. Must be a power of two and ≥ FETCH_WIDTH+PIPE_WIDTH.
- ADDR_BITS, 32: PC width.
- INST_BITS, 32: instruction width.

Ports:
- clk, in, 1: clock. The block uses this single clock.
- rst_n, in, 1: reset, asynchronous and active-low.
- flush, in, 1: synchronous squash of all contents.
- fetch_val, in, 1: packet offered.
- fetch_pc, in, ADDR_BITS: PC of lane 0 (packet-aligned base).
- fetch_insts, in, FETCH_WIDTH*INST_BITS: lane i in bits [i*INST_BITS +: INST_BITS].
- fetch_mask, in, FETCH_WIDTH: lane-valid bits; the set bits form one contiguous run.
- fetch_rdy, out, 1: queue can take a full packet.
- dec_val, out, PIPE_WIDTH: per-lane valid; always a thermometer code from lane 0.
- dec_insts, out, PIPE_WIDTH×INST_BITS: oldest-first instructions.
- dec_pcs, out, PIPE_WIDTH×ADDR_BITS: matching PCs.
- dec_take, in, $clog2(PIPE_WIDTH+1): number of lanes consumed this cycle.
- count, out, $clog2(DEPTH+1): current occupancy.

## Operation
- Storage is a circular array of DEPTH entries {pc, inst}, with head, tail and count registers. Pointers wrap modulo DEPTH.
- Write (accept = fetch_val & fetch_rdy & ~flush):
  - Let s = index of the lowest set bit of fetch_mask and n = its popcount.
  - Lanes s..s+n-1 are compacted into slots tail..tail+n-1 (mod DEPTH).
  - Slot tail+k receives pc = fetch_pc + 4·(s+k).
  - tail += n.
  - fetch_mask = 0 with fetch_val = 1 is accepted as a no-op (n = 0).
- fetch_rdy = (DEPTH − count) ≥ FETCH_WIDTH. It is derived from registered count only; there is no combinational path from any input.
- Read:
  - dec_val[j] = (j < count).
  - dec_insts[j] and dec_pcs[j] come from slot head+j. Invalid lanes drive 0.
  - Outputs are not gated by dec_take (no combinational loop).
- Consume: eff_take = min(dec_take, popcount(dec_val)); head += eff_take. Decode must not exceed available lanes; the RTL clamps and the bench asserts.
- Next count = count + n − eff_take. Simultaneous write and consume in one cycle is fully supported.
- Flush has highest priority:
  - head, tail and count go to 0 next cycle.
  - A same-cycle write and consume are both discarded.
  - dec_val is 0 in the cycle after flush.
- Reset (rst_n low, asynchronous):
  - head, tail and count are 0; dec_val = 0; dec_insts and dec_pcs = 0; fetch_rdy = 1.
  - Storage contents are not reset and are don't-care.
  - A reset mid-operation discards everything; the first post-reset write lands in slot 0.

## Timing
- Write-to-visible latency is 1 cycle. Data accepted at edge N appears on dec_* after edge N. There is no bypass when empty.
- Consume takes effect at the edge; the next lanes are presented the following cycle.
- fetch_rdy reflects occupancy after the previous edge. A full queue stays not-ready even when decode consumes in the same cycle; readiness updates one cycle later.
- count ≤ DEPTH always. Reaching DEPTH exactly is legal (count width covers it).
- All outputs are combinational from registers only.

## Structure
- uarch_pkg:
  - add FETCH_QUEUE_DEPTH;
  - add typedef fetch_entry_t {logic [CPU_ADDR_BITS-1:0] pc; logic [CPU_INST_BITS-1:0] inst;}.
  - Defaults take FETCH_WIDTH and PIPE_WIDTH from the package.
- One sub-module, fetch_lane_compact: a combinational module that, from mask and lanes, produces the start index s, count n and the compacted lanes with PCs.

## Test plan
- Reset then single write: fetch_pc=0x1000, mask=2'b11, insts {0xB,0xA}.
  - Next cycle: dec_val=2'b11, dec_insts[0]=0xA @0x1000, dec_insts[1]=0xB @0x1004, count=2.
- Unaligned and truncated packets:
  - mask=2'b10, pc=0x2000 → one entry 0x…@0x2004, dec_val=2'b01.
  - mask=2'b01 → entry @0x2000.
- Partial consume with simultaneous write:
  - count=3, dec_take=1, full packet written → count=4; head entry is the old second instruction.
- Fill, wrap and full:
  - Five 2-wide writes with no take (DEPTH=8): fetch_rdy drops after count reaches 8; the fifth write is blocked.
  - Then drain 2/cycle across the wrap point; PCs stay in order; fetch_rdy returns when count ≤ 6.
- Flush and reset priority:
  - flush asserted with a write and dec_take=2 in the same cycle → count=0, dec_val=0 next cycle.
  - Asynchronous rst_n pulse mid-drain → outputs zero immediately; the first new write lands at slot 0.
- Over-take clamp: count=1, dec_take=2 → count=0, head advances by 1, bench assertion fires.
